// File: rtl/mux8_pkg.sv
// Shared types and constants for the 8-source round-robin mux arbiter.
// Select encodings, beat/source types and output-stage state enum.
package mux8_pkg;

   localparam int unsigned NUM_SRC = 8;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned SEL_W   = 4;
   localparam int unsigned SRC_W   = 3;

   typedef logic [SEL_W-1:0]  sel_t;
   typedef logic [DATA_W-1:0] beat_t;
   typedef logic [SRC_W-1:0]  src_t;

   localparam sel_t SEL_SRC0 = 4'b0000;
   localparam sel_t SEL_SRC1 = 4'b0001;
   localparam sel_t SEL_SRC2 = 4'b0010;
   localparam sel_t SEL_SRC3 = 4'b0011;
   localparam sel_t SEL_SRC4 = 4'b0100;
   localparam sel_t SEL_SRC5 = 4'b0101;
   localparam sel_t SEL_SRC6 = 4'b0110;
   localparam sel_t SEL_SRC7 = 4'b0111;

   // Pointer value after reset, so that source 0 is searched first.
   localparam src_t LAST_RST = 3'd7;

   typedef enum logic [0:0] {
      StEmpty,
      StFull
   } arb_state_e;

   // The mux has a 4-bit select but only 8 inputs: the top bit is always 0.
   function automatic sel_t src_to_sel(input src_t src);
      return {1'b0, src};
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotating priority encoder: picks the first requester after 'last', wrapping mod 8.
// Purely combinational.
module rr_pick8
   import mux8_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   input  logic [SRC_W-1:0]   last,
   output logic [SRC_W-1:0]   gnt_idx,
   output logic               gnt_any
);

   src_t cand;

   always_comb begin
      gnt_idx = last;
      gnt_any = 1'b0;
      cand    = last;
      // Offset 8 wraps back to 'last' itself, so it has the lowest priority.
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
         cand = last + src_t'(k);
         if (!gnt_any && req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin scheduler for an external 8:1 x 64-bit mux with a one-entry output register.
// Optional packet locking is enabled by defining MUX8_ARB_LOCK_EN (adds the in_last port).
module mux8_rr_arbiter
   import mux8_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_SRC-1:0]  in_valid,
   output logic [NUM_SRC-1:0]  in_ready,
`ifdef MUX8_ARB_LOCK_EN
   input  logic [NUM_SRC-1:0]  in_last,
`endif
   input  logic [DATA_W-1:0]   mux_out,
   output logic [SEL_W-1:0]    sel,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic [SRC_W-1:0]    out_src
);

   arb_state_e state_q, state_d;
   beat_t      out_data_q;
   src_t       out_src_q;
   src_t       last_q, last_d;

   src_t       pick_idx;
   logic       pick_any;
   src_t       gnt_idx;
   logic       gnt_any;
   logic       load;
   logic       xfer;

   rr_pick8 u_pick (
      .req     (in_valid),
      .last    (last_q),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

`ifdef MUX8_ARB_LOCK_EN
   logic locked_q, locked_d;

   // While locked, last_q already names the locked source; nobody else may win.
   always_comb begin
      gnt_idx = locked_q ? last_q : pick_idx;
      gnt_any = locked_q ? in_valid[last_q] : pick_any;
   end

   always_comb begin
      locked_d = locked_q;
      if (xfer) begin
         locked_d = !in_last[gnt_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         locked_q <= 1'b0;
      end else begin
         locked_q <= locked_d;
      end
   end
`else
   always_comb begin
      gnt_idx = pick_idx;
      gnt_any = pick_any;
   end
`endif

   // Handshake and mux control.
   always_comb begin
      load     = (state_q == StEmpty) || out_ready;
      xfer     = load && gnt_any && !rst;
      in_ready = '0;
      if (xfer) begin
         in_ready[gnt_idx] = 1'b1;
      end
      if (rst) begin
         sel = SEL_SRC0;
      end else begin
         sel = src_to_sel(gnt_any ? gnt_idx : last_q);
      end
      last_d = xfer ? gnt_idx : last_q;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StEmpty: begin
            if (xfer) begin
               state_d = StFull;
            end
         end
         StFull: begin
            if (!xfer && out_ready) begin
               state_d = StEmpty;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StEmpty;
         last_q     <= LAST_RST;
         out_data_q <= '0;
         out_src_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         if (xfer) begin
            out_data_q <= mux_out;
            out_src_q  <= gnt_idx;
         end
      end
   end

   assign out_valid = (state_q == StFull);
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

   ready_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
   sel_range_a:    assert property (@(posedge clk) sel <= SEL_SRC7);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomised and directed bench for mux8_rr_arbiter against a behavioural round-robin model.
// Build with MUX8_ARB_LOCK_EN defined to also exercise packet locking.
module tb_mux8_rr_arbiter;
   import mux8_pkg::*;

`ifdef MUX8_ARB_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_valid;
   logic [7:0]  in_ready;
   logic [7:0]  in_last;
   logic [63:0] mux_out;
   logic [3:0]  sel;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [2:0]  out_src;
   logic [63:0] src_data [8];

   always #5 clk = ~clk;

   assign mux_out = src_data[sel[2:0]];

   mux8_rr_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef MUX8_ARB_LOCK_EN
      .in_last   (in_last),
`endif
      .mux_out   (mux_out),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: what the output stage holds and who was granted last.
   bit          m_valid;
   logic [63:0] m_data;
   int          m_src;
   int          m_last;
   bit          m_locked;
   int          g_cur;
   bit          pin_en  = 1'b0;
   int          pin_idx = 0;
   logic [63:0] pin_val = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid  = 1'b0;
      m_data   = '0;
      m_src    = 0;
      m_last   = 7;
      m_locked = 1'b0;
   endtask

   // One clock cycle: drive, compare against the model, advance the model.
   task automatic cycle(input logic [7:0] iv, input logic ordy, input logic [7:0] il,
                        input logic r);
      int  g;
      bit  any;
      bit  xfer;
      logic [7:0] er;
      @(negedge clk);
      in_valid  = iv;
      out_ready = ordy;
      in_last   = il;
      rst       = r;
      for (int i = 0; i < 8; i++) src_data[i] = {$urandom(), $urandom()};
      if (pin_en) src_data[pin_idx] = pin_val;
      #1;
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("out_data", out_data, m_data);
      check("out_src", 64'(out_src), 64'(m_src));
      if (r) begin
         check("rst_ready", 64'(in_ready), 64'd0);
         check("rst_sel", 64'(sel), 64'd0);
         model_reset();
         g_cur = -1;
         return;
      end
      any = 1'b0;
      g   = m_last;
      if (m_locked) begin
         any = iv[m_last];
      end else begin
         for (int k = 1; k <= 8; k++) begin
            int c;
            c = (m_last + k) % 8;
            if (!any && iv[c]) begin
               any = 1'b1;
               g   = c;
            end
         end
      end
      xfer = (!m_valid || ordy) && any;
      er   = xfer ? (8'd1 << g) : 8'd0;
      check("in_ready", 64'(in_ready), 64'(er));
      check("sel", 64'(sel), 64'(any ? g : m_last));
      if (xfer) begin
         m_data  = src_data[g];
         m_src   = g;
         m_valid = 1'b1;
         m_last  = g;
         if (LOCK) m_locked = !il[g];
      end else if (ordy) begin
         m_valid = 1'b0;
      end
      g_cur = xfer ? g : -1;
   endtask

   task automatic do_reset();
      cycle(8'hFF, 1'b0, 8'h00, 1'b1);
      cycle(8'hFF, 1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      logic [2:0]  held_src;
      logic [63:0] held_data;
      rst       = 1'b1;
      in_valid  = '0;
      in_last   = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) src_data[i] = '0;
      model_reset();
      g_cur = -1;
      repeat (2) @(posedge clk);

      // Reset with everyone requesting, then source 0 goes first.
      do_reset();
      cycle(8'hFF, 1'b1, 8'hFF, 1'b0);
      check("first_ready", 64'(in_ready), 64'h01);

      // Full-rate rotation.
      do_reset();
      for (int k = 0; k < 16; k++) begin
         cycle(8'hFF, 1'b1, 8'hFF, 1'b0);
         check("rot_ready", 64'(in_ready), 64'(8'd1 << (k % 8)));
         if (k > 0) begin
            check("rot_src", 64'(out_src), 64'((k - 1) % 8));
            check("rot_valid", 64'(out_valid), 64'd1);
         end
      end

      // Wrap-around from 2 to 7 to 2.
      do_reset();
      cycle(8'b0000_0100, 1'b1, 8'hFF, 1'b0);
      check("wrap_sel2", 64'(sel), 64'h2);
      cycle(8'b1000_0100, 1'b1, 8'hFF, 1'b0);
      check("wrap_sel7", 64'(sel), 64'h7);
      cycle(8'b1000_0100, 1'b1, 8'hFF, 1'b0);
      check("wrap_sel2b", 64'(sel), 64'h2);

      // Backpressure holds the output stage.
      do_reset();
      cycle(8'hFF, 1'b1, 8'hFF, 1'b0);
      cycle(8'hFF, 1'b0, 8'hFF, 1'b0);
      held_src  = out_src;
      held_data = out_data;
      for (int k = 0; k < 5; k++) begin
         cycle(8'hFF, 1'b0, 8'hFF, 1'b0);
         check("stall_ready", 64'(in_ready), 64'd0);
         check("stall_src", 64'(out_src), 64'(held_src));
         check("stall_data", out_data, held_data);
      end
      cycle(8'hFF, 1'b1, 8'hFF, 1'b0);
      check("release_ready", 64'(in_ready), 64'h02);
      cycle(8'hFF, 1'b1, 8'hFF, 1'b0);
      check("release_src", 64'(out_src), 64'h1);

      // Single source streaming back-to-back.
      do_reset();
      pin_en  = 1'b1;
      pin_idx = 5;
      for (int k = 0; k < 5; k++) begin
         pin_val = {4'h5, 60'(k)};
         cycle((k < 4) ? 8'b0010_0000 : 8'h00, 1'b1, 8'hFF, 1'b0);
         if (k < 4) check("s5_sel", 64'(sel), 64'h5);
         if (k > 0) check("s5_data", out_data, {4'h5, 60'(k - 1)});
      end
      pin_en = 1'b0;

`ifdef MUX8_ARB_LOCK_EN
      // Packet lock: 3,3,3 then 1; reset mid-lock clears it.
      do_reset();
      cycle(8'b0000_1000, 1'b1, 8'h00, 1'b0);
      check("lock_g0", 64'(g_cur), 64'd3);
      cycle(8'b0000_1010, 1'b1, 8'h00, 1'b0);
      check("lock_g1", 64'(g_cur), 64'd3);
      cycle(8'b0000_0010, 1'b1, 8'h00, 1'b0);
      check("lock_hold", 64'(in_ready), 64'd0);
      cycle(8'b0000_1010, 1'b1, 8'b0000_1000, 1'b0);
      check("lock_g2", 64'(g_cur), 64'd3);
      cycle(8'b0000_1010, 1'b1, 8'h00, 1'b0);
      check("lock_g3", 64'(g_cur), 64'd1);
      do_reset();
      cycle(8'b0000_1000, 1'b1, 8'h00, 1'b0);
      do_reset();
      cycle(8'b0000_1010, 1'b1, 8'h00, 1'b0);
      check("lock_rst", 64'(sel), 64'h1);
`endif

      // Random traffic with occasional mid-operation resets.
      for (int k = 0; k < 3000; k++) begin
         logic [7:0] iv;
         logic [7:0] il;
         iv = 8'($urandom()) & 8'($urandom());
         il = 8'($urandom()) | 8'($urandom());
         cycle(iv, ($urandom_range(0, 9) < 7), il, ($urandom_range(0, 99) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
